gpio_output_bank_pio: RTL and testbench
=======================================

# gpio_output_bank_pio

Avalon-MM slave output PIO that drives a bank of FPGA output pins from HPS/NIOS register writes. It is the write-side counterpart of the input-bank PIOs in the SoC system and sits on the lightweight HPS-to-FPGA bridge. It drives traffic-light lamps and actuator strobes. Besides plain data, set and clear writes, it provides a hardware auto-clear pulse mode so that software can issue fixed-length strobes without timing them.

## Interface
- WIDTH, 6, number of output bits (1..32)
- RESET_VALUE, 0, value of the data register and out_port after reset
- CNT_WIDTH, 16, width of the pulse-length register and counter
- clk  in  1  system clock; all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- address  in  3  word register index
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe; a write occurs when chipselect=1 and write_n=0
- writedata  in  32  write data; bits above the used width are ignored
- readdata  out  32  registered read data; unused upper bits are 0
- out_port  out  WIDTH  pin drive, equal to the data register

## Operation
- Register map:
  - 0 DATA: R/W, full overwrite.
  - 2 PULSE_MASK: R/W, WIDTH bits.
  - 3 PULSE_LEN: R/W, CNT_WIDTH bits.
  - 4 OUTSET: W, DATA |= writedata. Reads as 0.
  - 5 OUTCLEAR: W, DATA &= ~writedata. Reads as 0.
  - 6 STATUS: R, bit0 = pulse_active (counter != 0). Writes are ignored.
  - 1 and 7: reserved. Read 0; writes are ignored.
- Reads: readdata is updated every cycle with the mux output for the current address. It is 0 for write-only and reserved addresses, and for an unselected address value. No read side effects.
- Pulse mode:
  - Trigger: a write to DATA or OUTSET with (writedata & PULSE_MASK) != 0 while PULSE_LEN != 0.
  - The trigger loads the counter with PULSE_LEN. A trigger while the counter is already running restarts it; there is a single shared counter.
  - While the counter is nonzero it decrements by 1 each cycle.
  - On the cycle the counter goes from 1 to 0, DATA &= ~PULSE_MASK. This is the expiry.
  - PULSE_LEN = 0 disables pulse mode. Masked bits then behave like normal bits.
- Simultaneous events, in priority order:
  - A DATA/OUTSET/OUTCLEAR write in the same cycle as expiry: the write result is applied and expiry clearing is suppressed. If that write is itself a trigger, the counter reloads; otherwise the counter ends at 0.
  - Writing PULSE_MASK or PULSE_LEN while the counter is running does not alter the counter. Expiry uses the PULSE_MASK value current at the expiry cycle.
  - An OUTCLEAR write never loads the counter.
- Reset mid-pulse: all state returns to reset values immediately and asynchronously. The counter becomes 0 and no expiry follows.

## Timing
- Reset values:
  - DATA and out_port = RESET_VALUE[WIDTH-1:0].
  - PULSE_MASK = 0, PULSE_LEN = 0, counter = 0.
  - readdata = 0.
- Write latency: a write sampled at edge k updates DATA at edge k, so out_port shows the new value after edge k.
- Read latency: 1 cycle. Address presented before edge k gives readdata valid after edge k (readLatency=1, no waitrequest).
- Pulse length: a trigger write at edge k with PULSE_LEN=L gives counter = L after edge k. Masked bits clear at edge k+L, so a masked bit is high for exactly L cycles.
- out_port is driven straight from a register, with no combinational path from the bus.

## Test plan
- Reset then read: assert reset_n=0 mid-cycle -> out_port=RESET_VALUE immediately. Reading addresses 0–7 returns DATA, 0, 0, 0, 0, 0, 0, 0.
- Set/clear: write DATA=0x05, OUTSET 0x02, OUTCLEAR 0x04 -> out_port sequence 0x05, 0x07, 0x03. Readback of address 0 = 0x03 one cycle after the address is presented.
- Pulse:
  - Setup: PULSE_MASK=0x20, PULSE_LEN=4.
  - Stimulus: OUTSET 0x21.
  - Required response: bit5 high for exactly 4 cycles, then out_port=0x01. STATUS bit0 is 1 during the pulse and 0 after.
- Retrigger and collision:
  - Retrigger: during a pulse, OUTSET 0x20 at count 2 -> counter reloads to 4, extending the pulse.
  - Collision: an OUTSET 0x01 write on the expiry cycle -> bit5 stays 1 and the counter ends at 0.
- Disabled and reset mid-pulse:
  - With PULSE_LEN=0, OUTSET 0x20 -> bit5 stays high indefinitely.
  - With PULSE_LEN=100 and a pulse running, pulse reset_n low at count 50 -> out_port=RESET_VALUE and STATUS=0, with no later clearing.
- Width/ignore: write 0xFFFFFFFF to DATA with WIDTH=6 -> out_port=0x3F and readdata=0x0000003F. Writes to addresses 1, 6 and 7 change nothing.

Source files
------------

// File: rtl/gpio_output_bank_pio_if.sv
// Avalon-MM slave bus bundle for the output-bank PIO: address, select,
// write strobe, write data and registered read data.
interface gpio_output_bank_pio_if;
   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;

   modport master (
      output address, chipselect, write_n, writedata,
      input  readdata
   );

   modport slave (
      input  address, chipselect, write_n, writedata,
      output readdata
   );
endinterface

// File: rtl/gpio_output_bank_pio.sv
// Output PIO bank: DATA/OUTSET/OUTCLEAR writes drive out_port, with a single
// shared down-counter that auto-clears PULSE_MASK bits after PULSE_LEN cycles.
module gpio_output_bank_pio #(
   parameter int unsigned WIDTH       = 6,
   parameter logic [31:0] RESET_VALUE = 32'h0,
   parameter int unsigned CNT_WIDTH   = 16
) (
   input  logic                   clk,
   input  logic                   reset_n,
   gpio_output_bank_pio_if.slave  bus,
   output logic [WIDTH-1:0]       out_port
);

   localparam logic [2:0] ADDR_DATA     = 3'd0;
   localparam logic [2:0] ADDR_MASK     = 3'd2;
   localparam logic [2:0] ADDR_LEN      = 3'd3;
   localparam logic [2:0] ADDR_OUTSET   = 3'd4;
   localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;
   localparam logic [2:0] ADDR_STATUS   = 3'd6;

   localparam logic [WIDTH-1:0] DATA_RESET = WIDTH'(RESET_VALUE);

   logic [WIDTH-1:0]     r_data;
   logic [WIDTH-1:0]     r_mask;
   logic [CNT_WIDTH-1:0] r_len;
   logic [CNT_WIDTH-1:0] r_cnt;
   logic [31:0]          r_readdata;

   logic                 w_write;
   logic [WIDTH-1:0]     w_wdata;
   logic                 w_expire;
   logic                 w_trigger;
   logic                 w_active;
   logic [WIDTH-1:0]     w_data_nxt;
   logic [WIDTH-1:0]     w_mask_nxt;
   logic [CNT_WIDTH-1:0] w_len_nxt;
   logic [CNT_WIDTH-1:0] w_cnt_nxt;
   logic [31:0]          w_rd_mux;

   assign w_write  = bus.chipselect & ~bus.write_n;
   assign w_wdata  = WIDTH'(bus.writedata);
   assign w_active = (r_cnt != '0);
   assign w_expire = (r_cnt == CNT_WIDTH'(1));

   // Only DATA and OUTSET writes that touch a masked bit can start a pulse.
   assign w_trigger = w_write
                    && ((bus.address == ADDR_DATA) || (bus.address == ADDR_OUTSET))
                    && ((w_wdata & r_mask) != '0)
                    && (r_len != '0);

   // Data register: a bus write in the expiry cycle wins over the auto-clear.
   always_comb begin
      w_data_nxt = r_data;
      if (w_write && (bus.address == ADDR_DATA)) begin
         w_data_nxt = w_wdata;
      end else if (w_write && (bus.address == ADDR_OUTSET)) begin
         w_data_nxt = r_data | w_wdata;
      end else if (w_write && (bus.address == ADDR_OUTCLEAR)) begin
         w_data_nxt = r_data & ~w_wdata;
      end else if (w_expire) begin
         w_data_nxt = r_data & ~r_mask;
      end
   end

   always_comb begin
      w_mask_nxt = r_mask;
      w_len_nxt  = r_len;
      if (w_write && (bus.address == ADDR_MASK)) begin
         w_mask_nxt = w_wdata;
      end
      if (w_write && (bus.address == ADDR_LEN)) begin
         w_len_nxt = CNT_WIDTH'(bus.writedata);
      end
   end

   always_comb begin
      w_cnt_nxt = r_cnt;
      if (w_trigger) begin
         w_cnt_nxt = r_len;
      end else if (w_active) begin
         w_cnt_nxt = r_cnt - CNT_WIDTH'(1);
      end
   end

   // Read mux; write-only and reserved locations return zero.
   always_comb begin
      w_rd_mux = 32'h0;
      case (bus.address)
         ADDR_DATA:   w_rd_mux = 32'(r_data);
         ADDR_MASK:   w_rd_mux = 32'(r_mask);
         ADDR_LEN:    w_rd_mux = 32'(r_len);
         ADDR_STATUS: w_rd_mux = 32'(w_active);
         default:     w_rd_mux = 32'h0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_data     <= DATA_RESET;
         r_mask     <= '0;
         r_len      <= '0;
         r_cnt      <= '0;
         r_readdata <= 32'h0;
      end else begin
         r_data     <= w_data_nxt;
         r_mask     <= w_mask_nxt;
         r_len      <= w_len_nxt;
         r_cnt      <= w_cnt_nxt;
         r_readdata <= w_rd_mux;
      end
   end

   assign out_port     = r_data;
   assign bus.readdata = r_readdata;

endmodule

// File: tb/tb_gpio_output_bank_pio.sv
// Scoreboarded bench for gpio_output_bank_pio: expectations are queued as
// stimulus is applied and popped when out_port/readdata are sampled.
module tb_gpio_output_bank_pio;
   localparam int unsigned WIDTH = 6;
   localparam logic [31:0] RV    = 32'h0000_002A;
   localparam int unsigned CNTW  = 16;

   typedef struct {
      string       name;
      logic [31:0] val;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [WIDTH-1:0] out_port;
   exp_t             sb[$];
   int               n_vec  = 0;
   int               n_miss = 0;

   gpio_output_bank_pio_if bus_if ();

   gpio_output_bank_pio #(
      .WIDTH      (WIDTH),
      .RESET_VALUE(RV),
      .CNT_WIDTH  (CNTW)
   ) dut (
      .clk     (clk),
      .reset_n (rst_n),
      .bus     (bus_if),
      .out_port(out_port)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, got running, want finished");
      $fatal(1);
   end

   task automatic push(input string name, input logic [31:0] v);
      exp_t e;
      e.name = name;
      e.val  = v;
      sb.push_back(e);
   endtask

   // Called at a falling edge; the write is sampled at the next rising edge.
   task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
      bus_if.address    = a;
      bus_if.chipselect = 1'b1;
      bus_if.write_n    = 1'b0;
      bus_if.writedata  = d;
      @(negedge clk);
      bus_if.chipselect = 1'b0;
      bus_if.write_n    = 1'b1;
   endtask

   task automatic test_reset();
      exp_t e;
      bus_write(3'd0, 32'h11);
      push("reset_async_out", RV);
      #2 rst_n = 1'b0;
      #1;
      e = sb.pop_front(); n_vec++;
      if (32'(out_port) !== e.val) begin
         n_miss++; $display("FAIL %s: got %h, want %h", e.name, 32'(out_port), e.val);
      end
      #1 rst_n = 1'b1;
      @(negedge clk);
      for (int a = 0; a < 8; a++) begin
         push($sformatf("reset_read_a%0d", a), (a == 0) ? RV : 32'h0);
         bus_if.address = 3'(a);
         @(negedge clk);
         e = sb.pop_front(); n_vec++;
         if (bus_if.readdata !== e.val) begin
            n_miss++; $display("FAIL %s: got %h, want %h", e.name, bus_if.readdata, e.val);
         end
      end
   endtask

   task automatic test_set_clear();
      exp_t        e;
      logic [2:0]  addrs[3] = '{3'd0, 3'd4, 3'd5};
      logic [31:0] wdat[3]  = '{32'h05, 32'h02, 32'h04};
      logic [31:0] want[3]  = '{32'h05, 32'h07, 32'h03};
      for (int i = 0; i < 3; i++) begin
         push($sformatf("setclr_out_%0d", i), want[i]);
         bus_write(addrs[i], wdat[i]);
         e = sb.pop_front(); n_vec++;
         if (32'(out_port) !== e.val) begin
            n_miss++; $display("FAIL %s: got %h, want %h", e.name, 32'(out_port), e.val);
         end
      end
      push("setclr_readback", 32'h03);
      bus_if.address = 3'd0;
      @(negedge clk);
      e = sb.pop_front(); n_vec++;
      if (bus_if.readdata !== e.val) begin
         n_miss++; $display("FAIL %s: got %h, want %h", e.name, bus_if.readdata, e.val);
      end
   endtask

   task automatic test_pulse();
      exp_t e;
      bus_write(3'd2, 32'h20);
      bus_write(3'd3, 32'd4);
      bus_write(3'd0, 32'h00);
      for (int i = 0; i < 4; i++) push($sformatf("pulse_high_%0d", i), 32'h21);
      push("pulse_after", 32'h01);
      bus_write(3'd4, 32'h21);
      bus_if.address = 3'd6;
      for (int i = 0; i < 4; i++) begin
         e = sb.pop_front(); n_vec++;
         if (32'(out_port) !== e.val) begin
            n_miss++; $display("FAIL %s: got %h, want %h", e.name, 32'(out_port), e.val);
         end
         if (i >= 1) begin
            n_vec++;
            if (bus_if.readdata !== 32'h1) begin
               n_miss++; $display("FAIL pulse_status_%0d: got %h, want %h", i, bus_if.readdata, 32'h1);
            end
         end
         @(negedge clk);
      end
      e = sb.pop_front(); n_vec++;
      if (32'(out_port) !== e.val) begin
         n_miss++; $display("FAIL %s: got %h, want %h", e.name, 32'(out_port), e.val);
      end
      push("pulse_status_done", 32'h0);
      @(negedge clk);
      e = sb.pop_front(); n_vec++;
      if (bus_if.readdata !== e.val) begin
         n_miss++; $display("FAIL %s: got %h, want %h", e.name, bus_if.readdata, e.val);
      end
   endtask

   task automatic test_retrigger();
      exp_t e;
      bus_write(3'd0, 32'h00);
      bus_write(3'd4, 32'h20);
      repeat (2) @(negedge clk);
      for (int i = 0; i < 4; i++) push($sformatf("retrig_high_%0d", i), 32'h20);
      push("retrig_after", 32'h00);
      bus_write(3'd4, 32'h20);
      for (int i = 0; i < 5; i++) begin
         e = sb.pop_front(); n_vec++;
         if (32'(out_port) !== e.val) begin
            n_miss++; $display("FAIL %s: got %h, want %h", e.name, 32'(out_port), e.val);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_collision();
      exp_t e;
      bus_write(3'd0, 32'h00);
      bus_write(3'd4, 32'h20);
      repeat (3) @(negedge clk);
      push("collide_out", 32'h21);
      push("collide_status", 32'h0);
      push("collide_out_later", 32'h21);
      bus_write(3'd4, 32'h01);
      e = sb.pop_front(); n_vec++;
      if (32'(out_port) !== e.val) begin
         n_miss++; $display("FAIL %s: got %h, want %h", e.name, 32'(out_port), e.val);
      end
      bus_if.address = 3'd6;
      @(negedge clk);
      e = sb.pop_front(); n_vec++;
      if (bus_if.readdata !== e.val) begin
         n_miss++; $display("FAIL %s: got %h, want %h", e.name, bus_if.readdata, e.val);
      end
      repeat (8) @(negedge clk);
      e = sb.pop_front(); n_vec++;
      if (32'(out_port) !== e.val) begin
         n_miss++; $display("FAIL %s: got %h, want %h", e.name, 32'(out_port), e.val);
      end
   endtask

   task automatic test_disabled();
      exp_t e;
      bus_write(3'd3, 32'd0);
      bus_write(3'd0, 32'h00);
      push("disabled_out", 32'h20);
      push("disabled_status", 32'h0);
      bus_write(3'd4, 32'h20);
      bus_if.address = 3'd6;
      repeat (20) @(negedge clk);
      e = sb.pop_front(); n_vec++;
      if (32'(out_port) !== e.val) begin
         n_miss++; $display("FAIL %s: got %h, want %h", e.name, 32'(out_port), e.val);
      end
      e = sb.pop_front(); n_vec++;
      if (bus_if.readdata !== e.val) begin
         n_miss++; $display("FAIL %s: got %h, want %h", e.name, bus_if.readdata, e.val);
      end
   endtask

   task automatic test_reset_mid_pulse();
      exp_t e;
      bus_write(3'd3, 32'd100);
      bus_write(3'd0, 32'h00);
      push("midrst_running_status", 32'h1);
      push("midrst_out_now", RV);
      push("midrst_status_now", 32'h0);
      push("midrst_out_later", RV);
      push("midrst_status_later", 32'h0);
      bus_write(3'd4, 32'h20);
      bus_if.address = 3'd6;
      repeat (50) @(negedge clk);
      e = sb.pop_front(); n_vec++;
      if (bus_if.readdata !== e.val) begin
         n_miss++; $display("FAIL %s: got %h, want %h", e.name, bus_if.readdata, e.val);
      end
      #2 rst_n = 1'b0;
      #1;
      e = sb.pop_front(); n_vec++;
      if (32'(out_port) !== e.val) begin
         n_miss++; $display("FAIL %s: got %h, want %h", e.name, 32'(out_port), e.val);
      end
      e = sb.pop_front(); n_vec++;
      if (bus_if.readdata !== e.val) begin
         n_miss++; $display("FAIL %s: got %h, want %h", e.name, bus_if.readdata, e.val);
      end
      #1 rst_n = 1'b1;
      repeat (120) @(negedge clk);
      e = sb.pop_front(); n_vec++;
      if (32'(out_port) !== e.val) begin
         n_miss++; $display("FAIL %s: got %h, want %h", e.name, 32'(out_port), e.val);
      end
      e = sb.pop_front(); n_vec++;
      if (bus_if.readdata !== e.val) begin
         n_miss++; $display("FAIL %s: got %h, want %h", e.name, bus_if.readdata, e.val);
      end
   endtask

   task automatic test_width_ignore();
      exp_t        e;
      logic [2:0]  raddr[6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd6, 3'd7};
      logic [31:0] rwant[6] = '{32'h3F, 32'h0, 32'h3F, 32'h1234, 32'h0, 32'h0};
      bus_write(3'd3, 32'd0);
      push("width_out", 32'h3F);
      bus_write(3'd0, 32'hFFFF_FFFF);
      e = sb.pop_front(); n_vec++;
      if (32'(out_port) !== e.val) begin
         n_miss++; $display("FAIL %s: got %h, want %h", e.name, 32'(out_port), e.val);
      end
      bus_write(3'd2, 32'hFFFF_FFFF);
      bus_write(3'd3, 32'hFFFF_1234);
      push("ignore_out", 32'h3F);
      bus_write(3'd1, 32'h0);
      bus_write(3'd6, 32'h0);
      bus_write(3'd7, 32'h0);
      e = sb.pop_front(); n_vec++;
      if (32'(out_port) !== e.val) begin
         n_miss++; $display("FAIL %s: got %h, want %h", e.name, 32'(out_port), e.val);
      end
      for (int i = 0; i < 6; i++) begin
         push($sformatf("width_read_a%0d", raddr[i]), rwant[i]);
         bus_if.address = raddr[i];
         @(negedge clk);
         e = sb.pop_front(); n_vec++;
         if (bus_if.readdata !== e.val) begin
            n_miss++; $display("FAIL %s: got %h, want %h", e.name, bus_if.readdata, e.val);
         end
      end
   endtask

   initial begin
      bus_if.address    = 3'd0;
      bus_if.chipselect = 1'b0;
      bus_if.write_n    = 1'b1;
      bus_if.writedata  = 32'h0;
      rst_n             = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      test_reset();
      test_set_clear();
      test_pulse();
      test_retrigger();
      test_collision();
      test_disabled();
      test_reset_mid_pulse();
      test_width_ignore();

      n_vec++;
      if (sb.size() != 0) begin
         n_miss++; $display("FAIL scoreboard_drain: got %0d left, want 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
